// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns engine: one 32-bit column per cycle behind valid/ready handshakes.
// Optional macro INV_MIX_PARALLEL_EN instantiates four column units and finishes in one BUSY cycle.
module inv_mix_columns_iter #(
  parameter int         NCOL   = 4,
  parameter logic [1:0] AES192 = 2'h2,
  parameter logic [1:0] AES256 = 2'h3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] S,
  input  logic [4:0]   round,
  input  logic [1:0]   mode,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] S_,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int CW = 128 / NCOL;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, BYPASS = 2'd2, DONE = 2'd3} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [CW-1:0] inv_col(input logic [CW-1:0] c);
    logic [7:0] a  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [CW-1:0] r;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[CW-1-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[CW-1-8*i -: 8] = me[i] ^ mb[(i + 1) % 4] ^ md[(i + 2) % 4] ^ m9[(i + 3) % 4];
    end
    return r;
  endfunction

  state_t         state_q, state_d;
  logic [127:0]   work_q, work_d;
  logic [127:0]   s_out_q, s_out_d;
  logic           out_valid_q, out_valid_d;
  logic           bypass_hit_s;
`ifndef INV_MIX_PARALLEL_EN
  logic [1:0]     col_q, col_d;
  logic [CW-1:0]  col_sel_s;
  logic [127:0]   work_nx_s;
`endif

  assign in_ready  = (state_q == IDLE);
  assign S_        = s_out_q;
  assign out_valid = out_valid_q;

  // Bypass decision taken on the round/mode values present at the acceptance edge.
  always_comb begin
    if (mode == AES192) begin
      bypass_hit_s = (round == 5'h0E);
    end else if (mode == AES256) begin
      bypass_hit_s = (round == 5'h10);
    end else begin
      bypass_hit_s = (round == 5'h0C);
    end
  end

`ifndef INV_MIX_PARALLEL_EN
  // Shared column unit: select column col_q, transform it, splice it back.
  always_comb begin
    work_nx_s = work_q;
    case (col_q)
      2'd0:    col_sel_s = work_q[127:96];
      2'd1:    col_sel_s = work_q[95:64];
      2'd2:    col_sel_s = work_q[63:32];
      2'd3:    col_sel_s = work_q[31:0];
      default: col_sel_s = work_q[127:96];
    endcase
    case (col_q)
      2'd0:    work_nx_s[127:96] = inv_col(col_sel_s);
      2'd1:    work_nx_s[95:64]  = inv_col(col_sel_s);
      2'd2:    work_nx_s[63:32]  = inv_col(col_sel_s);
      2'd3:    work_nx_s[31:0]   = inv_col(col_sel_s);
      default: work_nx_s         = work_q;
    endcase
  end
`endif

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    s_out_d = s_out_q;
`ifndef INV_MIX_PARALLEL_EN
    col_d   = col_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d = S;
          if (bypass_hit_s) begin
            state_d = BYPASS;
          end else begin
            state_d = BUSY;
`ifndef INV_MIX_PARALLEL_EN
            col_d   = 2'd0;
`endif
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
`ifdef INV_MIX_PARALLEL_EN
        work_d  = {inv_col(work_q[127:96]), inv_col(work_q[95:64]),
                   inv_col(work_q[63:32]),  inv_col(work_q[31:0])};
        s_out_d = work_d;
        state_d = DONE;
`else
        work_d = work_nx_s;
        col_d  = col_q + 2'd1;
        if (col_q == 2'd3) begin
          s_out_d = work_nx_s;
          state_d = DONE;
        end else begin
          state_d = BUSY;
        end
`endif
      end
      BYPASS: begin
        s_out_d = work_q;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    out_valid_d = (state_d == DONE);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      work_q      <= 128'h0;
      s_out_q     <= 128'h0;
      out_valid_q <= 1'b0;
`ifndef INV_MIX_PARALLEL_EN
      col_q       <= 2'd0;
`endif
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      s_out_q     <= s_out_d;
      out_valid_q <= out_valid_d;
`ifndef INV_MIX_PARALLEL_EN
      col_q       <= col_d;
`endif
    end
  end

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Directed self-checking bench for inv_mix_columns_iter; expected values come from
// hand-computed vectors and a forward MixColumns model (inverse verified by round trip).
module tb_inv_mix_columns_iter;

  logic         clk;
  logic         rst_n;
  logic [127:0] S;
  logic [4:0]   round;
  logic [1:0]   mode;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] S_;
  logic         out_valid;
  logic         out_ready;

  int total;
  int bad;

`ifdef INV_MIX_PARALLEL_EN
  localparam int NORM_LAT = 1;
`else
  localparam int NORM_LAT = 4;
`endif

  inv_mix_columns_iter dut (
    .clk(clk), .rst_n(rst_n), .S(S), .round(round), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .S_(S_),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  // Forward MixColumns on one column, used to build inputs whose inverse is known.
  function automatic logic [31:0] fwd_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  function automatic logic [127:0] fwd_state(input logic [127:0] s);
    return {fwd_col(s[127:96]), fwd_col(s[95:64]), fwd_col(s[63:32]), fwd_col(s[31:0])};
  endfunction

  task automatic start_op(input logic [127:0] s, input logic [4:0] rnd, input logic [1:0] md);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    S = s; round = rnd; mode = md; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    S = 128'h0; round = 5'h0; mode = 2'h0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    total++;
    if (S_ !== 128'h0) begin bad++; $display("FAIL reset_S_ got=%h exp=0", S_); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_known();
    int lat;
    logic [127:0] exp_s;
    exp_s = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    start_op(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 5'h01, 2'h0);
    wait_valid(lat);
    total++;
    if (lat != NORM_LAT) begin bad++; $display("FAIL known_latency got=%0d exp=%0d", lat, NORM_LAT); end
    total++;
    if (S_ !== exp_s) begin bad++; $display("FAIL known_result got=%h exp=%h", S_, exp_s); end
    finish_op();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL known_handshake in_ready=%0b out_valid=%0b exp 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_bypass();
    logic [127:0] s0;
    logic [1:0]   md [3];
    logic [4:0]   rd [3];
    int lat;
    s0 = 128'h00112233445566778899aabbccddeeff;
    md[0] = 2'h2; rd[0] = 5'h0E;
    md[1] = 2'h3; rd[1] = 5'h10;
    md[2] = 2'h0; rd[2] = 5'h0C;
    for (int i = 0; i < 3; i++) begin
      start_op(s0, rd[i], md[i]);
      wait_valid(lat);
      total++;
      if (lat != 1) begin bad++; $display("FAIL bypass_latency[%0d] got=%0d exp=1", i, lat); end
      total++;
      if (S_ !== s0) begin bad++; $display("FAIL bypass_result[%0d] got=%h exp=%h", i, S_, s0); end
      finish_op();
    end
    // AES-256 at round 0C is an ordinary round: the transform must be applied.
    start_op(fwd_state(s0), 5'h0C, 2'h3);
    wait_valid(lat);
    total++;
    if (lat != NORM_LAT) begin bad++; $display("FAIL nobypass_latency got=%0d exp=%0d", lat, NORM_LAT); end
    total++;
    if (S_ !== s0) begin bad++; $display("FAIL nobypass_result got=%h exp=%h", S_, s0); end
    finish_op();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [127:0] exp_s;
    exp_s = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    start_op(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 5'h03, 2'h1);
    wait_valid(lat);
    for (int i = 0; i < 10; i++) begin
      total++;
      if (S_ !== exp_s || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL backpressure_hold[%0d] S_=%h ov=%0b ir=%0b exp %h/1/0", i, S_, out_valid, in_ready, exp_s);
      end
      @(posedge clk); #1;
    end
    finish_op();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || S_ !== exp_s) begin
      bad++; $display("FAIL backpressure_release ir=%0b ov=%0b S_=%h exp 1/0/%h", in_ready, out_valid, S_, exp_s);
    end
  endtask

  task automatic test_ignored_input();
    int lat;
    logic [127:0] x;
    x = 128'hd4d4d4d5_01234567_89abcdef_f0e1d2c3;
    start_op(fwd_state(x), 5'h02, 2'h2);
    // Attempted second transfer with bypass-triggering controls while busy.
    S = 128'hffffffff_00000000_ffffffff_00000000; round = 5'h0C; mode = 2'h0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    total++;
    if (S_ !== x) begin bad++; $display("FAIL ignored_result got=%h exp=%h", S_, x); end
    finish_op();
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL ignored_no_second ov=%0b ir=%0b exp 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [127:0] exp_s;
    start_op(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 5'h01, 2'h0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    total++;
    if (out_valid !== 1'b0 || S_ !== 128'h0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_mid ov=%0b S_=%h ir=%0b exp 0/0/1", out_valid, S_, in_ready);
    end
    repeat (6) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_mid_no_valid got=%0b exp=0", out_valid); end
    end
    exp_s = {4{32'hd4d4d4d5}};
    start_op({4{32'hd5d5d7d6}}, 5'h04, 2'h0);
    wait_valid(lat);
    total++;
    if (S_ !== exp_s || lat != NORM_LAT) begin
      bad++; $display("FAIL reset_mid_recover S_=%h lat=%0d exp %h/%0d", S_, lat, exp_s, NORM_LAT);
    end
    finish_op();
  endtask

  task automatic test_round_trip();
    int lat;
    logic [127:0] x;
    logic [1:0]   md;
    for (int i = 0; i < 1000; i++) begin
      x  = {$urandom, $urandom, $urandom, $urandom};
      md = 2'($urandom_range(0, 3));
      start_op(fwd_state(x), 5'h05, md);
      wait_valid(lat);
      total++;
      if (S_ !== x || lat != NORM_LAT) begin
        bad++; $display("FAIL round_trip[%0d] got=%h lat=%0d exp=%h/%0d", i, S_, lat, x, NORM_LAT);
      end
      finish_op();
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [127:0] a;
    logic [127:0] b;
    a = 128'h00112233445566778899aabbccddeeff;
    b = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    start_op(a, 5'h0E, 2'h2);
    wait_valid(lat);
    finish_op();
    // finish_op returns one cycle after the handshake edge; accept immediately.
    S = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6; round = 5'h01; mode = 2'h0; in_valid = 1'b1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%0b exp=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    total++;
    if (S_ !== b || lat != NORM_LAT) begin
      bad++; $display("FAIL b2b_result got=%h lat=%0d exp=%h/%0d", S_, lat, b, NORM_LAT);
    end
    finish_op();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_known();
    test_bypass();
    test_backpressure();
    test_ignored_input();
    test_reset_mid();
    test_back_to_back();
    test_round_trip();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
